// File: rtl/max3_window_stream.sv
// Streaming max-of-3 front end: slides a three-sample window over accepted
// samples and registers {max, winning slot} with the ties-to-later-slot rule.
module max3_window_stream #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [1:0]       out_idx,
   output logic [1:0]       fill_cnt
);

   typedef enum logic {
      S_FILL = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   localparam logic [1:0] IDX_OLDEST = 2'd0;
   localparam logic [1:0] IDX_MIDDLE = 2'd1;
   localparam logic [1:0] IDX_NEWEST = 2'd2;

   state_e           state_q;
   logic [1:0]       fill_cnt_q;
   // Only two samples are stored: on an accept the post-shift window is
   // {win_mid_q, win_new_q, in_data}, so the pre-shift oldest is never read.
   logic [WIDTH-1:0] win_mid_q;
   logic [WIDTH-1:0] win_new_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_max_q;
   logic [1:0]       out_idx_q;

   logic             accept;
   logic             produce;
   logic [WIDTH-1:0] res_max_d;
   logic [1:0]       res_idx_d;

   // in_ready never depends on in_valid; rst_n gating keeps it low in reset.
   assign in_ready = rst_n && !flush && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign produce  = accept && ((state_q == S_RUN) || (fill_cnt_q == 2'd2));

   // Nested compare: x = post-shift oldest, y = middle, z = newest.
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      res_max_d = in_data;
      res_idx_d = IDX_NEWEST;
      if (win_mid_q > win_new_q) begin
         if (win_mid_q > in_data) begin
            res_max_d = win_mid_q;
            res_idx_d = IDX_OLDEST;
         end
      end else if (win_new_q > in_data) begin
         res_max_d = win_new_q;
         res_idx_d = IDX_MIDDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FILL;
         fill_cnt_q  <= 2'd0;
         win_mid_q   <= '0;
         win_new_q   <= '0;
         out_valid_q <= 1'b0;
         out_max_q   <= '0;
         out_idx_q   <= IDX_OLDEST;
      end else if (flush) begin
         state_q     <= S_FILL;
         fill_cnt_q  <= 2'd0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            win_mid_q <= win_new_q;
            win_new_q <= in_data;
            if (state_q == S_FILL) begin
               fill_cnt_q <= fill_cnt_q + 2'd1;
               if (fill_cnt_q == 2'd2) begin
                  state_q <= S_RUN;
               end
            end
         end
         if (produce) begin
            out_valid_q <= 1'b1;
            out_max_q   <= res_max_d;
            out_idx_q   <= res_idx_d;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_max   = out_max_q;
   assign out_idx   = out_idx_q;
   assign fill_cnt  = fill_cnt_q;

endmodule
